// File: rtl/freelist_pkg.sv
// Shared constants for the physical-register free list.
package freelist_pkg;

  localparam int DEF_PREG_NUM = 64;
  localparam int DEF_LREG_NUM = 32;
  localparam int DEF_FL_DEPTH = DEF_PREG_NUM - DEF_LREG_NUM;

  // Two rename slots and two commit slots per cycle.
  localparam int NUM_LANES = 2;

  // Pointer width: index bits plus one wrap bit.
  function automatic int fl_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int FL_PTR_WIDTH = fl_ptr_width(DEF_FL_DEPTH);

endpackage

// File: rtl/freelist_mem.sv
// Free-list storage: one entry per free preg, NUM_LANES write and read ports.
module freelist_mem
  import freelist_pkg::*;
#(
  parameter int DEPTH    = DEF_FL_DEPTH,
  parameter int W        = $clog2(DEF_PREG_NUM),
  parameter int IW       = $clog2(DEPTH),
  parameter int RST_BASE = DEF_LREG_NUM,
  parameter int LANES    = NUM_LANES
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [LANES-1:0]           wr_en_i,
  input  logic [LANES-1:0][IW-1:0]   wr_idx_i,
  input  logic [LANES-1:0][W-1:0]    wr_data_i,
  input  logic [LANES-1:0][IW-1:0]   rd_idx_i,
  output logic [LANES-1:0][W-1:0]    rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Reset loads the pregs not mapped to architectural regs; commits append.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= W'(RST_BASE + i);
    end else begin
      for (int l = 0; l < LANES; l++)
        if (wr_en_i[l]) mem_q[wr_idx_i[l]] <= wr_data_i[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_rd
    assign rd_data_o[l] = mem_q[rd_idx_i[l]];
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: dual allocate, dual release, one-cycle flush recovery.
module freelist
  import freelist_pkg::*;
#(
  parameter int PREG_NUM = DEF_PREG_NUM,
  parameter int LREG_NUM = DEF_LREG_NUM,
  parameter int FL_DEPTH = PREG_NUM - LREG_NUM
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        rn2fl_instr0_lrd_valid,
  output logic [$clog2(PREG_NUM)-1:0] fl2rn_instr0prd,
  input  logic                        rn2fl_instr1_lrd_valid,
  output logic [$clog2(PREG_NUM)-1:0] fl2rn_instr1prd,
  output logic                        freelist_can_alloc,
  input  logic                        flush_valid,
  input  logic                        rob2fl_commit0_valid,
  input  logic [$clog2(PREG_NUM)-1:0] rob2fl_commit0_old_prd,
  input  logic                        rob2fl_commit1_valid,
  input  logic [$clog2(PREG_NUM)-1:0] rob2fl_commit1_old_prd,
  output logic [$clog2(FL_DEPTH):0]   fl_count
);

  localparam int PW  = fl_ptr_width(FL_DEPTH);
  localparam int IW  = PW - 1;
  localparam int PRW = $clog2(PREG_NUM);

  // head: next speculative grant; arch_head: next grant not yet committed
  // away; tail: next release slot. MSB of each is the wrap bit.
  logic [PW-1:0] head_q, head_d, arch_q, arch_d, tail_q, tail_d;
  logic [PW-1:0] count, n_alloc, n_rel;
  logic          g0, g1, c0, c1;

  logic [NUM_LANES-1:0]           wr_en;
  logic [NUM_LANES-1:0][IW-1:0]   wr_idx, rd_idx;
  logic [NUM_LANES-1:0][PRW-1:0]  wr_data, rd_data;

  function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p, input logic [PW-1:0] n);
    return p + n;
  endfunction

  assign count              = tail_q - head_q;
  assign fl_count           = count;
  assign freelist_can_alloc = (count >= PW'(2));

  // Grants need two free entries so a dual request can never underflow.
  assign g0 = rn2fl_instr0_lrd_valid & freelist_can_alloc & ~flush_valid;
  assign g1 = rn2fl_instr1_lrd_valid & freelist_can_alloc & ~flush_valid;
  assign c0 = rob2fl_commit0_valid;
  assign c1 = rob2fl_commit1_valid;

  assign n_alloc = PW'(g0) + PW'(g1);
  assign n_rel   = PW'(c0) + PW'(c1);

  // Each commit retires one allocation; flush rewinds head to the committed point.
  always_comb begin
    arch_d = ptr_adv(arch_q, n_rel);
    tail_d = ptr_adv(tail_q, n_rel);
    head_d = flush_valid ? arch_d : ptr_adv(head_q, n_alloc);
  end

  // Pointer registers; tail starts one full lap ahead so the list is full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      arch_q <= '0;
      tail_q <= PW'(FL_DEPTH);
    end else begin
      head_q <= head_d;
      arch_q <= arch_d;
      tail_q <= tail_d;
    end
  end

  // Slot 1 packs behind slot 0 when both release.
  assign wr_en[0]   = c0;
  assign wr_en[1]   = c1;
  assign wr_idx[0]  = tail_q[IW-1:0];
  assign wr_idx[1]  = tail_q[IW-1:0] + IW'(c0);
  assign wr_data[0] = rob2fl_commit0_old_prd;
  assign wr_data[1] = rob2fl_commit1_old_prd;

  // instr1 takes the entry behind instr0 only if instr0 is also asking.
  assign rd_idx[0] = head_q[IW-1:0];
  assign rd_idx[1] = rn2fl_instr0_lrd_valid ? head_q[IW-1:0] + IW'(1) : head_q[IW-1:0];

  assign fl2rn_instr0prd = rd_data[0];
  assign fl2rn_instr1prd = rd_data[1];

  freelist_mem #(
    .DEPTH    (FL_DEPTH),
    .W        (PRW),
    .IW       (IW),
    .RST_BASE (LREG_NUM),
    .LANES    (NUM_LANES)
  ) u_mem (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  // Releasing more than was allocated would push the count past the buffer size.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    (tail_d - head_d) <= PW'(FL_DEPTH));

  // Commit slot 1 is only meaningful alongside slot 0.
  a_commit_order: assert property (@(posedge clock) disable iff (!reset_n)
    rob2fl_commit1_valid |-> rob2fl_commit0_valid);

endmodule

// File: tb/tb_freelist.sv
// Free-list bench: directed vector table plus randomized traffic against a queue model.
module tb_freelist;

  localparam int PN = 64;
  localparam int LN = 32;
  localparam int FD = 32;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       r0, r1, fl, c0, c1;
  logic [5:0] o0, o1, p0, p1;
  logic       can;
  logic [5:0] cnt;

  freelist #(.PREG_NUM(PN), .LREG_NUM(LN), .FL_DEPTH(FD)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .rn2fl_instr0_lrd_valid (r0),
    .fl2rn_instr0prd        (p0),
    .rn2fl_instr1_lrd_valid (r1),
    .fl2rn_instr1prd        (p1),
    .freelist_can_alloc     (can),
    .flush_valid            (fl),
    .rob2fl_commit0_valid   (c0),
    .rob2fl_commit0_old_prd (o0),
    .rob2fl_commit1_valid   (c1),
    .rob2fl_commit1_old_prd (o1),
    .fl_count               (cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ends one time unit after a rising edge, with reset released.
  task automatic do_reset();
    r0 = 0; r1 = 0; fl = 0; c0 = 0; c1 = 0; o0 = '0; o1 = '0;
    reset_n = 1'b0;
    #7;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  typedef struct {
    bit rst;
    bit a0, a1, f, k0, k1;
    int q0, q1;
    int x0, x1, xc, xn;   // -1: not checked
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit a0, bit a1, bit f, bit k0, bit k1,
                              int q0, int q1, int x0, int x1, int xc, int xn);
    vec_t v;
    v.rst = rst; v.a0 = a0; v.a1 = a1; v.f = f; v.k0 = k0; v.k1 = k1;
    v.q0 = q0; v.q1 = q1; v.x0 = x0; v.x1 = x1; v.xc = xc; v.xn = xn;
    tbl.push_back(v);
  endfunction

  // Random-phase reference model: freeq holds the 32 entries from the
  // committed head onward, spec counts speculative grants taken from it.
  typedef struct { int lreg; int np; int op; } rob_t;
  rob_t rob[$];
  int   freeq[$];
  int   spec;
  int   map[LN], amap[LN];
  bit   busy[PN];

  initial begin
    int   nc, ecnt, np0, np1;
    bit   a0, a1, f, ecan, g0, g1;
    rob_t e;

    reset_n = 1'b1;
    r0 = 0; r1 = 0; fl = 0; c0 = 0; c1 = 0; o0 = '0; o1 = '0;

    // Reset state, 15 dual grants, drain to empty, stall at empty.
    add(1, 0,0,0,0,0, 0,0, 32,32,1,32);
    for (int i = 0; i < 15; i++) add(0, 1,1,0,0,0, 0,0, 32+2*i, 33+2*i, 1, 32-2*i);
    add(0, 0,0,0,0,0, 0,0, 62,62,1,2);
    add(0, 1,1,0,0,0, 0,0, 62,63,1,2);
    add(0, 1,1,0,0,0, 0,0, 32,33,0,0);
    add(0, 0,0,0,0,0, 0,0, 32,32,0,0);
    // Single-slot grants.
    add(1, 0,1,0,0,0, 0,0, 32,32,1,32);
    add(0, 0,1,0,0,0, 0,0, 33,33,1,31);
    add(0, 1,0,0,0,0, 0,0, 34,35,1,30);
    add(0, 1,1,0,0,0, 0,0, 35,36,1,29);
    add(0, 0,0,0,0,0, 0,0, 37,37,1,27);
    // Allocate 4, release 5 and 7, drain until they come back in order.
    add(1, 1,1,0,0,0, 0,0, 32,33,1,32);
    add(0, 1,1,0,0,0, 0,0, 34,35,1,30);
    add(0, 0,0,0,1,1, 5,7, 36,36,1,28);
    for (int i = 0; i < 14; i++) add(0, 1,1,0,0,0, 0,0, 36+2*i, 37+2*i, 1, 30-2*i);
    add(0, 1,1,0,0,0, 0,0, 5,7,1,2);
    add(0, 0,0,0,0,0, 0,0, 34,34,0,0);
    // Allocate 6, commit 2, flush.
    add(1, 1,1,0,0,0, 0,0, 32,33,1,32);
    add(0, 1,1,0,0,0, 0,0, 34,35,1,30);
    add(0, 1,1,0,0,0, 0,0, 36,37,1,28);
    add(0, 0,0,0,1,1, 10,11, 38,38,1,26);
    add(0, 0,0,1,0,0, 0,0, 38,38,1,28);
    add(0, 0,0,0,0,0, 0,0, 34,34,1,32);
    // Flush with same-cycle dual commit and suppressed dual request.
    add(1, 1,1,0,0,0, 0,0, 32,33,1,32);
    add(0, 1,1,0,0,0, 0,0, 34,35,1,30);
    add(0, 1,1,1,1,1, 20,21, 36,37,1,28);
    add(0, 0,0,0,0,0, 0,0, 34,34,1,32);
    for (int i = 0; i < 15; i++) add(0, 1,1,0,0,0, 0,0, 34+2*i, 35+2*i, 1, 32-2*i);
    add(0, 1,1,0,0,0, 0,0, 20,21,1,2);
    add(0, 0,0,0,0,0, 0,0, 34,34,0,0);
    // Mid-operation reset restores original contents.
    add(1, 1,1,0,0,0, 0,0, 32,33,1,32);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      r0 = tbl[i].a0; r1 = tbl[i].a1; fl = tbl[i].f;
      c0 = tbl[i].k0; c1 = tbl[i].k1;
      o0 = 6'(tbl[i].q0); o1 = 6'(tbl[i].q1);
      @(negedge clock);
      if (tbl[i].x0 >= 0) chk($sformatf("vec%0d prd0", i), int'(p0), tbl[i].x0);
      if (tbl[i].x1 >= 0) chk($sformatf("vec%0d prd1", i), int'(p1), tbl[i].x1);
      if (tbl[i].xc >= 0) chk($sformatf("vec%0d can_alloc", i), int'(can), tbl[i].xc);
      if (tbl[i].xn >= 0) chk($sformatf("vec%0d count", i), int'(cnt), tbl[i].xn);
      @(posedge clock); #1;
    end

    // Randomized traffic.
    do_reset();
    freeq.delete(); rob.delete(); spec = 0;
    for (int i = 0; i < FD; i++) freeq.push_back(LN + i);
    for (int i = 0; i < LN; i++) begin map[i] = i; amap[i] = i; end
    for (int i = 0; i < PN; i++) busy[i] = (i < LN);

    for (int cyc = 0; cyc < 600; cyc++) begin
      a0 = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 29) == 0);
      nc = $urandom_range(0, 2);
      if (nc > rob.size()) nc = rob.size();
      r0 = a0; r1 = a1; fl = f;
      c0 = (nc >= 1); c1 = (nc == 2);
      o0 = '0; o1 = '0;
      if (nc >= 1) o0 = 6'(rob[0].op);
      if (nc == 2) o1 = 6'(rob[1].op);

      @(negedge clock);
      ecnt = FD - spec;
      ecan = (ecnt >= 2);
      g0 = a0 && ecan && !f;
      g1 = a1 && ecan && !f;
      np0 = 0; np1 = 0;
      chk($sformatf("rnd%0d count", cyc), int'(cnt), ecnt);
      chk($sformatf("rnd%0d can_alloc", cyc), int'(can), int'(ecan));
      if (g0) begin
        np0 = freeq[spec];
        chk($sformatf("rnd%0d prd0", cyc), int'(p0), np0);
        chk($sformatf("rnd%0d dup prd0", cyc), int'(busy[p0]), 0);
        busy[np0] = 1'b1;
      end
      if (g1) begin
        np1 = a0 ? freeq[spec+1] : freeq[spec];
        chk($sformatf("rnd%0d prd1", cyc), int'(p1), np1);
        chk($sformatf("rnd%0d dup prd1", cyc), int'(busy[p1]), 0);
        busy[np1] = 1'b1;
      end

      @(posedge clock);
      for (int k = 0; k < nc; k++) begin
        e = rob.pop_front();
        busy[e.op] = 1'b0;
        amap[e.lreg] = e.np;
        void'(freeq.pop_front());
        freeq.push_back(e.op);
        spec--;
      end
      if (f) begin
        foreach (rob[k]) busy[rob[k].np] = 1'b0;
        rob.delete();
        for (int k = 0; k < LN; k++) map[k] = amap[k];
        spec = 0;
      end else begin
        if (g0) begin
          e.lreg = $urandom_range(0, LN-1); e.np = np0; e.op = map[e.lreg];
          map[e.lreg] = np0; rob.push_back(e); spec++;
        end
        if (g1) begin
          e.lreg = $urandom_range(0, LN-1); e.np = np1; e.op = map[e.lreg];
          map[e.lreg] = np1; rob.push_back(e); spec++;
        end
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
